// File: rtl/dft_stream_pkg.sv
// dft_stream_pkg: shared defaults, capture state type and lane slicing for the dft output stream.
package dft_stream_pkg;
  localparam int DFT_LANES = 32;
  localparam int DFT_WIDTH = 64;
  localparam int DFT_BEATS = 32;
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} cap_state_t;
  function automatic int lane_base(input int lane, input int width);
    return lane * width;
  endfunction
endpackage

// File: rtl/dft_out_capture_if.sv
// dft_out_capture_if: single-word valid/ready stream drained from a captured frame.
interface dft_out_capture_if
  import dft_stream_pkg::*;
#(
  parameter int WIDTH = DFT_WIDTH,
  parameter int IDX_W = $clog2(DFT_LANES * DFT_BEATS)
);
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             rd_last;
  logic [IDX_W-1:0] rd_index;
  modport master (output rd_data, rd_valid, rd_last, rd_index, input rd_ready);
  modport slave (input rd_data, rd_valid, rd_last, rd_index, output rd_ready);
endinterface

// File: rtl/dft_frame_ram.sv
// dft_frame_ram: frame buffer with one write port and a registered row read.
module dft_frame_ram #(
  parameter int DW = 2048,
  parameter int DEPTH = 32,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/dft_out_capture.sv
// dft_out_capture: captures one dft_top output frame and drains it as a natural-order word stream.
module dft_out_capture
  import dft_stream_pkg::*;
#(
  parameter int LANES = DFT_LANES,
  parameter int WIDTH = DFT_WIDTH,
  parameter int BEATS = DFT_BEATS,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(LANES * BEATS),
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1,
  localparam int RW = BEATS > 1 ? $clog2(BEATS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   next_out,
  input  logic [LANES*WIDTH-1:0] Y,
  dft_out_capture_if.master      rd,
  output logic                   busy,
  output logic                   overrun,
  output logic [CNT_W-1:0]       drop_cnt
);
  cap_state_t             state_q, state_d;
  logic [RW-1:0]          beat_q, row_q, raddr;
  logic [LW-1:0]          lane_q;
  logic [IDX_W-1:0]       p_q, rd_index_q;
  logic [LANES*WIDTH-1:0] ram_row, cur_row_q, src_row;
  logic [WIDTH-1:0]       rd_data_q;
  logic [CNT_W-1:0]       drop_cnt_q;
  logic                   rd_valid_q, rd_last_q, overrun_q;
  logic                   cap_end, hs_last, load, drop, re, lane_wrap;

  assign cap_end   = state_q == CAPTURE && beat_q == RW'(BEATS - 1);
  assign hs_last   = rd_valid_q && rd.rd_ready && rd_last_q;
  assign load      = state_q == DRAIN && (!rd_valid_q || (rd.rd_ready && !rd_last_q));
  assign drop      = next_out && (state_q == CAPTURE || (state_q == DRAIN && !hs_last));
  assign lane_wrap = lane_q == LW'(LANES - 1);
  // The RAM output register holds the next row; it is consumed on lane 0 and refilled at once.
  assign re        = cap_end || (load && lane_q == '0 && row_q != RW'(BEATS - 1));
  assign raddr     = cap_end ? '0 : row_q + 1'b1;
  assign src_row   = lane_q == '0 ? ram_row : cur_row_q;

  dft_frame_ram #(.DW(LANES * WIDTH), .DEPTH(BEATS)) u_ram (
    .clk   (clk),
    .we    (state_q == CAPTURE),
    .waddr (beat_q),
    .wdata (Y),
    .re    (re),
    .raddr (raddr),
    .rdata (ram_row)
  );

  always_comb begin
    state_d = state_q == IDLE    ? (next_out ? CAPTURE : IDLE) :
              state_q == CAPTURE ? (cap_end ? DRAIN : CAPTURE) :
              hs_last            ? (next_out ? CAPTURE : IDLE) : DRAIN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      row_q      <= '0;
      lane_q     <= '0;
      p_q        <= '0;
      cur_row_q  <= '0;
      rd_data_q  <= '0;
      rd_index_q <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= state_q == CAPTURE ? beat_q + 1'b1 : '0;
      if (state_d == CAPTURE) begin
        row_q  <= '0;
        lane_q <= '0;
        p_q    <= '0;
      end else if (load) begin
        lane_q <= lane_wrap ? '0 : lane_q + 1'b1;
        row_q  <= lane_wrap ? row_q + 1'b1 : row_q;
        p_q    <= p_q + 1'b1;
      end
      if (load) begin
        rd_data_q  <= src_row[lane_base(int'(lane_q), WIDTH) +: WIDTH];
        rd_index_q <= p_q;
        rd_last_q  <= p_q == IDX_W'(LANES * BEATS - 1);
        rd_valid_q <= 1'b1;
        if (lane_q == '0) cur_row_q <= ram_row;
      end else if (hs_last) begin
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
      end
      if (drop) begin
        overrun_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign rd.rd_data  = rd_data_q;
  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_last  = rd_last_q;
  assign rd.rd_index = rd_index_q;
  assign busy        = state_q != IDLE;
  assign overrun     = overrun_q;
  assign drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_dft_out_capture.sv
// tb_dft_out_capture: randomized and directed frames checked against a frame-level reference model.
module tb_dft_out_capture;
  localparam int L = 32;
  localparam int B = 32;
  localparam int N = L * B;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic next_out = 1'b0;
  logic [L*W-1:0] Y = '0;
  logic busy, overrun;
  logic [1:0] drop_cnt;

  dft_out_capture_if #(.WIDTH(W), .IDX_W(10)) rd_if ();

  dft_out_capture #(.CNT_W(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .next_out (next_out),
    .Y        (Y),
    .rd       (rd_if),
    .busy     (busy),
    .overrun  (overrun),
    .drop_cnt (drop_cnt)
  );

  int cyc = 0;
  int t_start = -1000;
  int ready_mode = 0;
  int vectors = 0;
  int miscompares = 0;
  logic [63:0] y_base = '0;
  bit y_rnd = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Stub for dft_top: beat j of the tracked frame carries y_base + j*L + lane, otherwise noise.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < L; k++) begin
      int j;
      j = cyc - t_start - 1;
      Y[k*W +: W] = (!y_rnd && j >= 0 && j < B) ? y_base + 64'(j * L + k) : {$urandom, $urandom};
    end
    rd_if.rd_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (cyc % 5) < 3 : 1'($urandom_range(0, 1));
  end

  // Reference model: a frame is a list of N words; capture fills it, drain walks it.
  logic [63:0] mframe [N];
  int m_cap = -1;
  int m_n = -1;
  bit m_drain = 1'b0;
  bit m_ovr = 1'b0;
  bit m_rst = 1'b0;
  int m_drops = 0;
  bit m_free, m_last_hs;

  always @(posedge clk) begin
    m_rst = reset;
    if (reset) begin
      m_cap = -1;
      m_n = -1;
      m_drain = 1'b0;
      m_ovr = 1'b0;
      m_drops = 0;
    end else begin
      m_free = m_cap < 0 && !m_drain;
      m_last_hs = m_n == N - 1 && rd_if.rd_ready;
      if (next_out && !(m_free || m_last_hs)) begin
        m_drops++;
        m_ovr = 1'b1;
      end
      if (m_drain) begin
        if (m_n < 0) m_n = 0;
        else if (rd_if.rd_ready) begin
          if (m_n == N - 1) begin
            m_n = -1;
            m_drain = 1'b0;
          end else m_n++;
        end
      end
      if (m_cap >= 0) begin
        for (int k = 0; k < L; k++) mframe[m_cap*L + k] = Y[k*W +: W];
        m_cap++;
        if (m_cap == B) begin
          m_cap = -1;
          m_drain = 1'b1;
        end
      end
      if (next_out && (m_free || m_last_hs)) m_cap = 0;
    end
  end

  always @(negedge clk) begin
    chk("rd_valid", 64'(rd_if.rd_valid), 64'(m_n >= 0));
    chk("rd_last", 64'(rd_if.rd_last), 64'(m_n == N - 1));
    if (m_n >= 0) begin
      chk("rd_data", rd_if.rd_data, mframe[m_n]);
      chk("rd_index", 64'(rd_if.rd_index), 64'(m_n));
    end
    if (m_rst) begin
      chk("rst_data", rd_if.rd_data, 64'd0);
      chk("rst_index", 64'(rd_if.rd_index), 64'd0);
    end
    chk("busy", 64'(busy), 64'(m_cap >= 0 || m_drain));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drops > 3 ? 3 : m_drops));
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic pulse(input logic [63:0] base, input bit rnd);
    @(posedge clk); #1;
    y_base = base;
    y_rnd = rnd;
    t_start = cyc;
    next_out = 1'b1;
    @(posedge clk); #1 next_out = 1'b0;
  endtask

  task automatic drop_pulse();
    @(posedge clk); #1 next_out = 1'b1;
    @(posedge clk); #1 next_out = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    chk("idle", 64'(busy), 64'd0);
  endtask

  task automatic wait_word(input int idx, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rd_if.rd_valid && rd_if.rd_index == 10'(idx)) && n < budget);
    chk("reach_word", 64'(rd_if.rd_index), 64'(idx));
  endtask

  task automatic run_random(input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1;
      next_out = $urandom_range(0, 299) == 0;
      n++;
    end while (busy && n < budget);
    next_out = 1'b0;
    chk("rand_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int t0, n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // single frame, always ready: latency and last-word timing pinned by hand
    ready_mode = 0;
    pulse(64'd0, 1'b0);
    t0 = t_start;
    n = 0;
    while (!rd_if.rd_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_valid_lat", 64'(cyc - t0), 64'd34);
    chk("first_word", rd_if.rd_data, 64'd0);
    n = 0;
    while (!(rd_if.rd_valid && rd_if.rd_last) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("last_lat", 64'(cyc - t0), 64'd1057);
    chk("last_word", rd_if.rd_data, 64'd1023);
    chk("model_pin", mframe[777], 64'd777);
    wait_idle(10);

    // backpressure 3-on/2-off
    ready_mode = 1;
    pulse(64'd0, 1'b0);
    wait_idle(3000);

    // overrun during capture and during drain
    do_reset();
    ready_mode = 0;
    pulse(64'd0, 1'b0);
    repeat (19) @(posedge clk);
    #1 next_out = 1'b1;
    @(posedge clk); #1 next_out = 1'b0;
    wait_word(500, 1500);
    drop_pulse();
    wait_idle(1500);
    chk("ovr_drops", 64'(drop_cnt), 64'd2);
    chk("ovr_flag", 64'(overrun), 64'd1);

    // back-to-back: next frame starts on the last handshake
    do_reset();
    pulse(64'd0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rd_if.rd_valid && rd_if.rd_last) && n < 1500);
    next_out = 1'b1;
    t_start = cyc;
    y_base = 64'd1024;
    @(posedge clk); #1 next_out = 1'b0;
    wait_idle(1500);
    chk("b2b_drops", 64'(drop_cnt), 64'd0);
    chk("b2b_model_pin", mframe[5], 64'd1029);

    // reset during capture (beat 7) and during drain (word 300)
    do_reset();
    ready_mode = 2;
    pulse(64'd0, 1'b0);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    pulse(64'd4096, 1'b0);
    wait_word(300, 2500);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    pulse(64'd8192, 1'b0);
    wait_idle(3000);

    // drop counter saturation (2-bit counter)
    do_reset();
    ready_mode = 0;
    pulse(64'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      repeat (150) @(posedge clk);
      drop_pulse();
    end
    wait_idle(1500);
    chk("sat_drops", 64'(drop_cnt), 64'd3);
    chk("sat_flag", 64'(overrun), 64'd1);

    // random data, random ready, sporadic extra frame starts
    do_reset();
    ready_mode = 2;
    for (int i = 0; i < 3; i++) begin
      pulse(64'd0, 1'b1);
      run_random(8000);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1);
  end
endmodule
